// File: rtl/nmi_gen_multi_pkg.sv
// Shared types, constants and helpers for the multi-channel NMI generator.
package nmi_gen_multi_pkg;

  // Per-channel receiver FSM states; StSigint is only reachable when
  // NMI_GEN_MULTI_SIGINT_EN is defined.
  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StPing,
    StEsc,
    StSigint
  } esc_state_e;

  // {n,p} encodings of the differential pairs.
  localparam logic [1:0] EscRxIdle    = 2'b10;
  localparam logic [1:0] EscTxIdle    = 2'b10;
  localparam logic [1:0] EscTxActive  = 2'b01;
  localparam logic [1:0] EscRxPing    = 2'b01;

  // Increment v, holding at 2^w-1 (w in 1..16).
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input int unsigned w);
    logic [16:0] max_val;
    max_val = (17'd1 << w) - 17'd1;
    if ({1'b0, v} >= max_val) begin
      return v;
    end
    return v + 16'd1;
  endfunction

endpackage

// File: rtl/esc_rx_lite.sv
// Single-channel escalation receiver: ping/escalation handshake on a
// differential {n,p} pair. Optional macro: NMI_GEN_MULTI_SIGINT_EN adds a
// signal-integrity state entered after two consecutive cycles of p==n.
module esc_rx_lite
  import nmi_gen_multi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] esc_tx_i,
  output logic [1:0] esc_rx_o,
  output logic       esc_en_o
);

  esc_state_e state_q;
  logic       tx_active;

  assign tx_active = (esc_tx_i == EscTxActive);

`ifdef NMI_GEN_MULTI_SIGINT_EN
  logic tx_invalid;
  logic sigint_q;
  assign tx_invalid = (esc_tx_i[0] == esc_tx_i[1]);
`endif

  // Receiver FSM with registered rx response and escalation enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      esc_rx_o <= EscRxIdle;
      esc_en_o <= 1'b0;
`ifdef NMI_GEN_MULTI_SIGINT_EN
      sigint_q <= 1'b0;
`endif
    end else begin
`ifdef NMI_GEN_MULTI_SIGINT_EN
      sigint_q <= tx_invalid;
      if (state_q != StSigint && sigint_q && tx_invalid) begin
        state_q  <= StSigint;
        esc_en_o <= 1'b1;
        esc_rx_o <= 2'b11;
      end else begin
`endif
        case (state_q)
          StIdle: begin
            esc_rx_o <= EscRxIdle;
            esc_en_o <= 1'b0;
            if (tx_active) state_q <= StCheck;
          end
          StCheck: begin
            if (tx_active) begin
              state_q  <= StEsc;
              esc_en_o <= 1'b1;
              esc_rx_o <= 2'b01;
            end else begin
              state_q  <= StPing;
              esc_rx_o <= EscRxPing;
            end
          end
          StPing: begin
            // One-cycle ping response; any tx activity now is ignored.
            state_q  <= StIdle;
            esc_rx_o <= EscRxIdle;
          end
          StEsc: begin
            if (tx_active) begin
              esc_rx_o <= ~esc_rx_o;
            end else begin
              state_q  <= StIdle;
              esc_en_o <= 1'b0;
              esc_rx_o <= EscRxIdle;
            end
          end
`ifdef NMI_GEN_MULTI_SIGINT_EN
          StSigint: begin
            if (esc_tx_i == EscTxIdle) begin
              state_q  <= StIdle;
              esc_en_o <= 1'b0;
              esc_rx_o <= EscRxIdle;
            end else begin
              esc_rx_o <= {~esc_rx_o[0], ~esc_rx_o[0]};
            end
          end
`endif
          default: begin
            state_q  <= StIdle;
            esc_en_o <= 1'b0;
            esc_rx_o <= EscRxIdle;
          end
        endcase
`ifdef NMI_GEN_MULTI_SIGINT_EN
      end
`endif
    end
  end

endmodule

// File: rtl/nmi_gen_multi.sv
// Multi-channel NMI generator: NumEsc escalation receivers with sticky
// interrupts, saturating event counters and first-event capture.
// Optional macro: NMI_GEN_MULTI_SIGINT_EN (signal-integrity state per channel).
module nmi_gen_multi
  import nmi_gen_multi_pkg::*;
#(
  parameter int unsigned NumEsc = 4,
  parameter int unsigned CntW   = 8,
  localparam int unsigned IdxW  = (NumEsc > 1) ? $clog2(NumEsc) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2*NumEsc-1:0]    esc_tx_i,
  output logic [2*NumEsc-1:0]    esc_rx_o,
  output logic [NumEsc-1:0]      esc_en_o,
  input  logic [NumEsc-1:0]      intr_enable_i,
  input  logic [NumEsc-1:0]      intr_test_i,
  input  logic [NumEsc-1:0]      intr_clr_i,
  input  logic [NumEsc-1:0]      cnt_clr_i,
  input  logic                   first_clr_i,
  output logic [NumEsc-1:0]      intr_state_o,
  output logic [NumEsc-1:0]      intr_o,
  output logic [NumEsc*CntW-1:0] esc_cnt_o,
  output logic                   first_vld_o,
  output logic [IdxW-1:0]        first_ch_o
);

  logic [NumEsc-1:0] esc_en_q;
  logic [NumEsc-1:0] event_vec;
  logic [CntW-1:0]   cnt_q [NumEsc];
  logic [IdxW-1:0]   first_idx;

  for (genvar k = 0; k < NumEsc; k++) begin : g_chan
    esc_rx_lite u_rx (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .esc_tx_i (esc_tx_i[2*k +: 2]),
      .esc_rx_o (esc_rx_o[2*k +: 2]),
      .esc_en_o (esc_en_o[k])
    );
    assign esc_cnt_o[k*CntW +: CntW] = cnt_q[k];
  end

  assign event_vec = esc_en_o & ~esc_en_q;
  assign intr_o    = intr_state_o & intr_enable_i;

  // Lowest-indexed channel among simultaneous events.
  always_comb begin
    first_idx = '0;
    for (int k = NumEsc - 1; k >= 0; k--) begin
      if (event_vec[k]) first_idx = IdxW'(k);
    end
  end

  // Edge history, sticky interrupts and first-event capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      esc_en_q     <= '0;
      intr_state_o <= '0;
      first_vld_o  <= 1'b0;
      first_ch_o   <= '0;
    end else begin
      esc_en_q     <= esc_en_o;
      // Set wins over a simultaneous clear.
      intr_state_o <= (intr_state_o & ~intr_clr_i) | event_vec | intr_test_i;
      if (first_clr_i || !first_vld_o) begin
        if (|event_vec) begin
          first_vld_o <= 1'b1;
          first_ch_o  <= first_idx;
        end else if (first_clr_i) begin
          first_vld_o <= 1'b0;
          first_ch_o  <= '0;
        end
      end
    end
  end

  // Per-channel saturating event counters; a clear with an event leaves 1.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NumEsc; k++) begin
      if (rst_i) begin
        cnt_q[k] <= '0;
      end else if (cnt_clr_i[k]) begin
        cnt_q[k] <= event_vec[k] ? CntW'(1) : '0;
      end else if (event_vec[k]) begin
        cnt_q[k] <= CntW'(sat_inc(16'(cnt_q[k]), CntW));
      end
    end
  end

endmodule

// File: doc/nmi_gen_multi.md
Name: nmi_gen_multi

Overview:
- Parametrised successor to the fixed 4-channel NMI generator: NumEsc escalation receiver channels, each with differential ping/escalation handshake, a sticky interrupt, and a saturating escalation-event counter.
- Adds first-event capture across channels and a per-channel counter clear.
- Sits as an escalation endpoint downstream of the alert handler. Register access uses a flat strobe interface rather than a bus adapter.

Parameters:
- NumEsc, 4, number of escalation channels (1..32).
- CntW, 8, width of each per-channel saturating event counter (1..16).
- IdxW, (NumEsc > 1) ? $clog2(NumEsc) : 1, derived localparam; width of the channel index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- esc_tx_i  in  2*NumEsc  per channel k, bits [2k+1:2k] = {n,p}. Valid idle is p=0,n=1; active is p=1,n=0.
- esc_rx_o  out  2*NumEsc  per channel k, {n,p} response.
- esc_en_o  out  NumEsc  escalation active per channel.
- intr_enable_i  in  NumEsc  interrupt enable.
- intr_test_i  in  NumEsc  single-cycle test strobe; sets state.
- intr_clr_i  in  NumEsc  write-1-to-clear of interrupt state.
- cnt_clr_i  in  NumEsc  zeroes the channel counter.
- first_clr_i  in  1  clears the first-event capture.
- intr_state_o  out  NumEsc  sticky interrupt state.
- intr_o  out  NumEsc  intr_state_o & intr_enable_i.
- esc_cnt_o  out  NumEsc*CntW  counter k at [k*CntW +: CntW].
- first_vld_o  out  1  first-event capture valid.
- first_ch_o  out  IdxW  index of the first escalating channel.

Behaviour:
- Reset, synchronous active-high, takes effect on the next edge:
  - all FSMs return to IDLE.
  - esc_rx_o = {1,0} per channel.
  - esc_en_o, intr_state_o, intr_o, first_vld_o, first_ch_o and all counters are 0.
  - A reset during escalation drops esc_en_o at the reset edge.
- Receiver FSM, one per channel. Inputs are sampled unregistered; state and outputs are registered.
  - IDLE: tx active -> CHECK; otherwise stay. rx = {1,0}.
  - CHECK: tx active -> ESC; tx idle -> PING; rx = {1,0}.
  - PING: rx = {0,1} for exactly 1 cycle, then -> IDLE. A tx-active input during PING is ignored; it re-enters CHECK from IDLE.
  - ESC: esc_en = 1. rx toggles every cycle, starting {0,1}. When tx is not active -> IDLE, and esc_en drops the same edge.
  - Result: esc_en_o rises 2 cycles after tx first goes active. A 1-cycle tx pulse produces a ping response in cycle +2.
- Event: per-channel rising edge of esc_en_o (a registered copy of the previous value is kept). Updates below occur 1 cycle after esc_en_o rises.
- intr_state:
  - set by event | intr_test_i; cleared by intr_clr_i.
  - set wins over a simultaneous clear.
  - intr_o is combinational from state and enable.
- Counter:
  - +1 per event, saturating at 2^CntW-1.
  - cnt_clr_i zeroes it; cnt_clr_i together with an event yields 1.
- First capture:
  - When first_vld_o = 0 and any event occurs: first_vld_o <= 1 and first_ch_o <= lowest index among the simultaneous events.
  - Further events do not overwrite the capture while first_vld_o = 1.
  - first_clr_i clears it; first_clr_i together with an event recaptures.
- intr_test_i does not affect the counters or first capture.

Optional Feature:
- Macro: NMI_GEN_MULTI_SIGINT_EN.
- Defined: adds state SIGINT, reachable from any state.
  - Entry: tx p==n for 2 consecutive cycles (a per-channel 1-bit detector); reset takes precedence.
  - In SIGINT: esc_en = 1 (counts as an event on entry), and rx = {t,t} with t toggling every cycle starting at 1.
  - Exit: first valid idle tx (p=0,n=1) -> IDLE.
- Not defined: p==n is treated as not-active. No SIGINT state and no detector flops.

Decomposition:
- Package nmi_gen_multi_pkg holds:
  - typedef esc_state_e {IDLE, CHECK, PING, ESC, SIGINT}.
  - rx idle constant ESC_RX_IDLE = 2'b10.
  - saturating-increment function.
- One sub-module, esc_rx_lite: a single-channel FSM with tx/rx/esc_en ports, instantiated NumEsc times in a generate loop.
- The top level holds interrupt, counter and first-capture logic.

Test Plan:
- Ping: NumEsc=4, ch1 tx active for 1 cycle, then idle -> esc_rx_o[3:2]=2'b01 exactly in cycle +2; esc_en_o=0; counter 0.
- Escalation: ch2 tx active for 6 cycles:
  - esc_en_o[2] is high from cycle +2 until 1 cycle after tx returns idle.
  - rx toggles.
  - intr_state_o[2]=1 and esc_cnt[2]=1.
  - With enable[2]=1, intr_o[2]=1.
- Saturation: CntW=2, 5 escalations on ch0 -> count reads 3; cnt_clr_i plus a simultaneous 6th event -> 1.
- First capture: ch3 and ch1 escalate in the same cycle -> first_ch_o=1, first_vld_o=1. A later ch0 event leaves first_ch_o at 1. first_clr_i plus a ch0 event -> first_ch_o=0.
- Test/clear priority: intr_test_i[0] and intr_clr_i[0] in the same cycle -> state=1. intr_clr_i alone -> 0. Counter unchanged.
- Reset mid-escalation: rst_i during ESC -> all outputs at reset values the next cycle; esc_rx_o=8'hAA. With SIGINT_EN, tx=2'b11 for 2 cycles -> esc_en_o=1 and rx=2'b11/2'b00 alternating.
